seq_math_unit: RTL
==================

Name: seq_math_unit

Overview:
- Multi-cycle, handshaked hardware counterpart of the team's math helper functions: ceil-log2, integer power, abs, max and min.
- Parametrised in operand and result width.
- POW and LOG2 iterate one step per clock.
- Reports overflow and illegal-opcode status.
- Sits as a DUT-side arithmetic helper in the HAVEN ALU environment. Processes one operation at a time with valid/ready on both sides.

Parameters:
- DATA_WIDTH, 8: width of operands IN_A and IN_B.
- RES_WIDTH, 16: width of OUT_RES. Must be >= DATA_WIDTH; elaboration error otherwise.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- IN_VLD  in  1  operation request valid.
- IN_RDY  out  1  unit ready to accept (registered).
- IN_OP  in  3  opcode: 0 LOG2, 1 POW, 2 ABS, 3 MAX, 4 MIN, 5-7 illegal.
- IN_A  in  DATA_WIDTH  operand A: signed; unsigned for LOG2.
- IN_B  in  DATA_WIDTH  operand B: signed for MAX/MIN; unsigned exponent for POW.
- OUT_VLD  out  1  result valid.
- OUT_RDY  in  1  consumer ready.
- OUT_RES  out  RES_WIDTH  signed result (LOG2 result is non-negative).
- OUT_OVF  out  1  true result not representable in signed RES_WIDTH.
- OUT_ERR  out  1  illegal opcode.

Behaviour:
- Reset (RST low, asynchronous):
  - State goes to IDLE.
  - IN_RDY=0, OUT_VLD=0, OUT_RES=0, OUT_OVF=0, OUT_ERR=0, all internal counters cleared.
  - IN_RDY rises at the first clock edge after RST deasserts.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
- FSM states IDLE, CALC, DONE.
  - IN_RDY=1 only in IDLE.
  - OUT_VLD=1 only in DONE.
- Acceptance:
  - An operation is accepted on a rising edge with IN_VLD & IN_RDY. That edge is the "accept edge".
  - Opcode and operands are latched on the accept edge and IN_RDY drops.
- Latency is counted in edges after the accept edge until OUT_VLD is high.
- ABS/MAX/MIN/illegal: accept edge goes to CALC for one cycle (latency 1).
  - ABS computes |A| sign-extended to RES_WIDTH.
  - MAX/MIN use a signed compare; on a tie, A is returned.
  - Illegal opcode: RES=0, ERR=1.
- LOG2 (ceil, unsigned A):
  - Accept edge sets a=0, m=1; m is DATA_WIDTH+1 bits wide so it cannot wrap.
  - Each CALC edge: if m<A then a++ and m<<=1; else go to DONE with RES=a.
  - A=0 or A=1 gives RES=0 with latency 1.
  - General latency is r+1, where r is the result.
- POW (A^B, B unsigned):
  - Accept edge sets acc=1, cnt=B.
  - Each CALC edge: if cnt!=0 then acc=acc*A (signed) and cnt--; else go to DONE.
  - B=0 gives RES=1. Latency is B+1.
  - Overflow: each product is computed at full width. If it exceeds the signed RES_WIDTH range, a sticky ovf flag is set. acc keeps the low RES_WIDTH bits (wrap) and iteration continues.
  - OUT_OVF = sticky flag.
- DONE:
  - OUT_RES, OUT_OVF and OUT_ERR are held stable until OUT_VLD & OUT_RDY.
  - The handshake edge returns the FSM to IDLE: OUT_VLD=0 and IN_RDY=1 from the next cycle.
  - Minimum spacing between accepts is latency+2 edges.
- IN_VLD while busy: ignored. The source must hold the request until IN_RDY.
- Simultaneous OUT_RDY and a new IN_VLD in DONE: no new accept. The request is taken on the following edge, from IDLE.
- OUT_RDY held high permanently is legal: each result is valid for exactly one cycle.
- Worst-case latency is 2^DATA_WIDTH (POW with B=max).

Decomposition:
- Package math_unit_pkg holds:
  - opcode enum op_t (LOG2, POW, ABS, MAX, MIN);
  - state enum state_t (IDLE, CALC, DONE);
  - opcode-width constant.
- One sub-module, sat_ovf_mult:
  - signed RES_WIDTH x DATA_WIDTH multiplier;
  - returns the wrapped RES_WIDTH product and an out-of-range flag;
  - used by the POW iteration.

Test Plan (DATA_WIDTH=8, RES_WIDTH=16):
- LOG2, A=5, OUT_RDY=1 -> OUT_VLD 4 edges after accept, RES=3, OVF=0. A=255 -> RES=8, latency 9. A=0 -> RES=0, latency 1.
- POW, A=-3, B=3 -> RES=-27 (0xFFE5), OVF=0, latency 4. A=7, B=0 -> RES=1, latency 1.
- POW, A=16, B=4 -> OVF=1, RES=0x0000, latency 5. A=2, B=14 -> RES=16384, OVF=0.
- ABS A=-128 -> RES=128, OVF=0. MAX(-5,3) -> 3. MIN(-5,3) -> -5 (0xFFFB). Each has latency 1. OP=6 -> RES=0, ERR=1.
- Backpressure: POW 3^2 with OUT_RDY low for 3 cycles after OUT_VLD -> RES=9 held stable, IN_RDY=0 throughout, and a pending IN_VLD is not accepted. IN_RDY=1 the cycle after OUT_RDY is raised.
- Reset: RST low during CALC of POW 2^10 -> all outputs 0 immediately (asynchronous), no OUT_VLD. IN_RDY=1 one edge after release. The next LOG2 A=8 gives RES=3.

Source files
------------

// File: rtl/math_unit_pkg.sv
// Shared opcode/state encodings for the sequential math helper.
package math_unit_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    LOG2 = 3'd0,
    POW  = 3'd1,
    ABS  = 3'd2,
    MAX  = 3'd3,
    MIN  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_math_unit_if.sv
// Request/response bundle of the math unit: valid/ready in, valid/ready out.
interface seq_math_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
);
  import math_unit_pkg::*;

  logic                  in_vld;
  logic                  in_rdy;
  logic [OP_WIDTH-1:0]   in_op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_vld;
  logic                  out_rdy;
  logic [RES_WIDTH-1:0]  out_res;
  logic                  out_ovf;
  logic                  out_err;

  modport master (
    output in_vld, in_op, in_a, in_b, out_rdy,
    input  in_rdy, out_vld, out_res, out_ovf, out_err
  );

  modport slave (
    input  in_vld, in_op, in_a, in_b, out_rdy,
    output in_rdy, out_vld, out_res, out_ovf, out_err
  );

endinterface

// File: rtl/sat_ovf_mult.sv
// Signed RES_WIDTH x DATA_WIDTH multiply returning the wrapped product
// plus a flag when the exact product does not fit in signed RES_WIDTH.
module sat_ovf_mult #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
) (
  input  logic signed [RES_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] mul,
  output logic signed [RES_WIDTH-1:0]  prod,
  output logic                         ovf
);

  localparam int PW = RES_WIDTH + DATA_WIDTH;

  logic signed [PW-1:0] full;
  logic [DATA_WIDTH:0]  top_bits;

  assign full     = PW'(acc) * PW'(mul);
  assign prod     = full[RES_WIDTH-1:0];
  // In range only if every bit above the result sign bit repeats it.
  assign top_bits = full[PW-1:RES_WIDTH-1];
  assign ovf      = !((&top_bits) || (~|top_bits));

endmodule

// File: rtl/seq_math_unit.sv
// Multi-cycle ceil-log2 / power / abs / max / min unit, one operation at a
// time; LOG2 and POW advance one step per clock.
module seq_math_unit
  import math_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
) (
  input logic             clk,
  input logic             rst_n,
  seq_math_unit_if.slave  io
);

  generate
    if (RES_WIDTH < DATA_WIDTH) begin : g_width_check
      $error("seq_math_unit: RES_WIDTH must be >= DATA_WIDTH");
    end
  endgenerate

  state_t                       state_reg, state_next;
  logic                         in_rdy_reg;
  logic [OP_WIDTH-1:0]          op_reg;
  logic [DATA_WIDTH-1:0]        a_reg, b_reg, cnt_reg;
  logic [DATA_WIDTH:0]          m_reg;
  logic [RES_WIDTH-1:0]         acc_reg, res_reg;
  logic                         ovf_reg, err_reg;
  logic                         accept, calc_done, mul_ovf;
  logic signed [RES_WIDTH-1:0]  a_ext, b_ext, abs_val, mul_res;

  assign accept  = (state_reg == IDLE) && io.in_vld && in_rdy_reg;
  assign a_ext   = RES_WIDTH'($signed(a_reg));
  assign b_ext   = RES_WIDTH'($signed(b_reg));
  // Negating the most negative value only stays negative when widths match.
  assign abs_val = a_reg[DATA_WIDTH-1] ? -a_ext : a_ext;

  sat_ovf_mult #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WIDTH  (RES_WIDTH)
  ) u_mult (
    .acc  (acc_reg),
    .mul  (a_reg),
    .prod (mul_res),
    .ovf  (mul_ovf)
  );

  always_comb begin
    calc_done = 1'b1;
    case (op_reg)
      LOG2:    calc_done = !(m_reg < {1'b0, a_reg});
      POW:     calc_done = (cnt_reg == '0);
      default: calc_done = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = CALC;
      CALC:    if (calc_done)  state_next = DONE;
      DONE:    if (io.out_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      in_rdy_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_rdy_reg <= (state_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
      m_reg   <= '0;
      acc_reg <= '0;
      res_reg <= '0;
      ovf_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg  <= io.in_op;
            a_reg   <= io.in_a;
            b_reg   <= io.in_b;
            cnt_reg <= io.in_b;
            m_reg   <= (DATA_WIDTH+1)'(1);
            // acc doubles as the LOG2 step count, so it starts at 0 there.
            acc_reg <= (io.in_op == POW) ? RES_WIDTH'(1) : '0;
            ovf_reg <= 1'b0;
            err_reg <= 1'b0;
          end
        end
        CALC: begin
          case (op_reg)
            LOG2: begin
              if (calc_done) begin
                res_reg <= acc_reg;
              end else begin
                acc_reg <= acc_reg + RES_WIDTH'(1);
                m_reg   <= m_reg << 1;
              end
            end
            POW: begin
              if (calc_done) begin
                res_reg <= acc_reg;
              end else begin
                acc_reg <= mul_res;
                ovf_reg <= ovf_reg | mul_ovf;
                cnt_reg <= cnt_reg - DATA_WIDTH'(1);
              end
            end
            ABS: begin
              res_reg <= abs_val;
              ovf_reg <= abs_val[RES_WIDTH-1];
            end
            MAX:     res_reg <= ($signed(a_reg) >= $signed(b_reg)) ? a_ext : b_ext;
            MIN:     res_reg <= ($signed(a_reg) <= $signed(b_reg)) ? a_ext : b_ext;
            default: begin
              res_reg <= '0;
              err_reg <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign io.in_rdy  = in_rdy_reg;
  assign io.out_vld = (state_reg == DONE);
  assign io.out_res = res_reg;
  assign io.out_ovf = ovf_reg;
  assign io.out_err = err_reg;

endmodule
